// File: rtl/dco_tune_pkg.sv
// Shared types and helpers for the DCO tuning-word controller.
// Build option: DCO_DITHER_EN enables first-order sigma-delta dither on the small bank.
package dco_tune_pkg;

    typedef enum logic [1:0] {
        PVT  = 2'b00,
        ACQ  = 2'b01,
        TRK  = 2'b10,
        HOLD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LOAD   = 2'b01,
        SETTLE = 2'b10
    } state_t;

    // Width needed to hold a binary code 0..side^2 inclusive.
    function automatic int cw(input int side);
        return $clog2(side * side + 1);
    endfunction

endpackage

// File: rtl/dco_mtx_enc.sv
// Binary code to rall/row/col matrix-select encoder for one square capacitor bank.
// Code v lights q=v/SIDE full rows, plus r=v%SIDE cells of row q, so the lit-cell count equals v.
module dco_mtx_enc
    import dco_tune_pkg::*;
#(
    parameter int SIDE = 16,
    parameter int CW   = cw(SIDE)
) (
    input  logic [CW-1:0]   code,
    output logic [SIDE-1:0] rall,
    output logic [SIDE-1:0] row,
    output logic [SIDE-1:0] col
);

    localparam logic [CW-1:0] SIDE_W = CW'(SIDE);

    logic [CW-1:0] q_s;
    logic [CW-1:0] r_s;

    // Split the code into full-row count and partial-row remainder
    always_comb begin
        q_s = code / SIDE_W;
        r_s = code % SIDE_W;
    end

    genvar i;
    generate
        for (i = 0; i < SIDE; i++) begin : g_line
            localparam logic [CW-1:0] IDX = CW'(i);
            assign rall[i] = (q_s > IDX);
            assign row[i]  = (r_s != {CW{1'b0}}) && (q_s == IDX);
            assign col[i]  = (r_s > IDX);
        end
    endgenerate

endmodule

// File: rtl/dco_tune_ctrl.sv
// DCO tuning-word controller: accepts L/M/S words through a valid/ready handshake,
// gates them by loop mode, saturates to bank size, and drives registered matrix selects.
// Build option: DCO_DITHER_EN adds sigma-delta dither of the small bank in TRK mode.
module dco_tune_ctrl
    import dco_tune_pkg::*;
#(
    parameter int N_L_SIDE   = 5,
    parameter int N_M_SIDE   = 16,
    parameter int N_S_SIDE   = 16,
    parameter int FRAC_W     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int CW_L       = cw(N_L_SIDE),
    parameter int CW_M       = cw(N_M_SIDE),
    parameter int CW_S       = cw(N_S_SIDE)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pd,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          mode,
    input  logic [CW_L-1:0]     tw_l,
    input  logic [CW_M-1:0]     tw_m,
    input  logic [CW_S-1:0]     tw_s,
    input  logic [FRAC_W-1:0]   tw_frac,
    output logic [N_L_SIDE-1:0] c_l_rall,
    output logic [N_L_SIDE-1:0] c_l_row,
    output logic [N_L_SIDE-1:0] c_l_col,
    output logic [N_M_SIDE-1:0] c_m_rall,
    output logic [N_M_SIDE-1:0] c_m_row,
    output logic [N_M_SIDE-1:0] c_m_col,
    output logic [N_S_SIDE-1:0] c_s_rall,
    output logic [N_S_SIDE-1:0] c_s_row,
    output logic [N_S_SIDE-1:0] c_s_col,
    output logic                busy,
    output logic                upd_done
);

    localparam logic [CW_L-1:0] MAX_L = CW_L'(N_L_SIDE * N_L_SIDE);
    localparam logic [CW_M-1:0] MAX_M = CW_M'(N_M_SIDE * N_M_SIDE);
    localparam logic [CW_S-1:0] MAX_S = CW_S'(N_S_SIDE * N_S_SIDE);
    localparam logic [CW_L-1:0] MID_L = CW_L'(N_L_SIDE * N_L_SIDE / 2);
    localparam logic [CW_M-1:0] MID_M = CW_M'(N_M_SIDE * N_M_SIDE / 2);
    localparam logic [CW_S-1:0] MID_S = CW_S'(N_S_SIDE * N_S_SIDE / 2);
    localparam int              CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_t          state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic            in_ready_s, accept_s, upd_done_s;
    mode_t           mode_s, cur_mode_r;
    logic [CW_L-1:0] code_l_r, sat_l_s, enc_l_in_s;
    logic [CW_M-1:0] code_m_r, sat_m_s, enc_m_in_s;
    logic [CW_S-1:0] code_s_r, sat_s_s, enc_s_in_s, s_eff_s;
    logic [N_L_SIDE-1:0] enc_l_rall_s, enc_l_row_s, enc_l_col_s;
    logic [N_M_SIDE-1:0] enc_m_rall_s, enc_m_row_s, enc_m_col_s;
    logic [N_S_SIDE-1:0] enc_s_rall_s, enc_s_row_s, enc_s_col_s;

    assign mode_s     = mode_t'(mode);
    assign in_ready_s = (state_r == IDLE) && !pd && !rst;
    assign accept_s   = in_valid && in_ready_s;
    assign in_ready   = in_ready_s;
    assign busy       = (state_r == LOAD) || (state_r == SETTLE);
    assign upd_done   = upd_done_s;
    assign sat_l_s    = (tw_l > MAX_L) ? MAX_L : tw_l;
    assign sat_m_s    = (tw_m > MAX_M) ? MAX_M : tw_m;
    assign sat_s_s    = (tw_s > MAX_S) ? MAX_S : tw_s;

    // FSM state and settle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
        end
    end

    // Next-state logic; power-down aborts any update without a done pulse
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        upd_done_s = 1'b0;
        if (pd) begin
            state_nx_s = IDLE;
            cnt_nx_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nx_s = LOAD;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                LOAD: begin
                    if (SETTLE_CYC == 0) begin
                        state_nx_s = IDLE;
                        upd_done_s = 1'b1;
                    end else begin
                        state_nx_s = SETTLE;
                        cnt_nx_s   = CNT_INIT;
                    end
                end
                SETTLE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nx_s = IDLE;
                        upd_done_s = 1'b1;
                    end else begin
                        cnt_nx_s = cnt_r - CNT_W'(1'b1);
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Bank code registers and current mode, loaded on accept according to mode
    always_ff @(posedge clk) begin
        if (rst) begin
            code_l_r   <= MID_L;
            code_m_r   <= MID_M;
            code_s_r   <= MID_S;
            cur_mode_r <= HOLD;
        end else if (accept_s) begin
            case (mode_s)
                PVT: begin
                    code_l_r   <= sat_l_s;
                    cur_mode_r <= PVT;
                end
                ACQ: begin
                    code_m_r   <= sat_m_s;
                    cur_mode_r <= ACQ;
                end
                TRK: begin
                    code_s_r   <= sat_s_s;
                    cur_mode_r <= TRK;
                end
                default: begin
                    cur_mode_r <= cur_mode_r;
                end
            endcase
        end else begin
            code_l_r   <= code_l_r;
            code_m_r   <= code_m_r;
            code_s_r   <= code_s_r;
            cur_mode_r <= cur_mode_r;
        end
    end

`ifdef DCO_DITHER_EN
    logic [FRAC_W-1:0] frac_r, acc_r;
    logic [FRAC_W:0]   sum_s;
    logic              dith_on_s, carry_s;

    assign dith_on_s = (cur_mode_r == TRK) && !pd;
    assign sum_s     = {1'b0, acc_r} + {1'b0, frac_r};
    assign carry_s   = dith_on_s && sum_s[FRAC_W];
    assign s_eff_s   = (carry_s && (code_s_r != MAX_S)) ? code_s_r + CW_S'(1'b1) : code_s_r;

    // Fractional word, captured only by TRK updates
    always_ff @(posedge clk) begin
        if (rst) begin
            frac_r <= {FRAC_W{1'b0}};
        end else if (accept_s && (mode_s == TRK)) begin
            frac_r <= tw_frac;
        end else begin
            frac_r <= frac_r;
        end
    end

    // Sigma-delta accumulator; restarts from zero on power-down or leaving TRK
    always_ff @(posedge clk) begin
        if (rst || pd) begin
            acc_r <= {FRAC_W{1'b0}};
        end else if (accept_s && (mode_s != TRK)) begin
            acc_r <= {FRAC_W{1'b0}};
        end else if (dith_on_s) begin
            acc_r <= sum_s[FRAC_W-1:0];
        end else begin
            acc_r <= acc_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = ^{tw_frac, cur_mode_r};
    assign s_eff_s  = code_s_r;
`endif

    // Reset forces the encoders to mid-scale so the select registers load it in the same cycle
    always_comb begin
        if (rst) begin
            enc_l_in_s = MID_L;
            enc_m_in_s = MID_M;
            enc_s_in_s = MID_S;
        end else begin
            enc_l_in_s = code_l_r;
            enc_m_in_s = code_m_r;
            enc_s_in_s = s_eff_s;
        end
    end

    dco_mtx_enc #(.SIDE(N_L_SIDE), .CW(CW_L)) u_enc_l (
        .code(enc_l_in_s), .rall(enc_l_rall_s), .row(enc_l_row_s), .col(enc_l_col_s)
    );
    dco_mtx_enc #(.SIDE(N_M_SIDE), .CW(CW_M)) u_enc_m (
        .code(enc_m_in_s), .rall(enc_m_rall_s), .row(enc_m_row_s), .col(enc_m_col_s)
    );
    dco_mtx_enc #(.SIDE(N_S_SIDE), .CW(CW_S)) u_enc_s (
        .code(enc_s_in_s), .rall(enc_s_rall_s), .row(enc_s_row_s), .col(enc_s_col_s)
    );

    // Select output registers; frozen while powered down
    always_ff @(posedge clk) begin
        if (rst || !pd) begin
            c_l_rall <= enc_l_rall_s;
            c_l_row  <= enc_l_row_s;
            c_l_col  <= enc_l_col_s;
            c_m_rall <= enc_m_rall_s;
            c_m_row  <= enc_m_row_s;
            c_m_col  <= enc_m_col_s;
            c_s_rall <= enc_s_rall_s;
            c_s_row  <= enc_s_row_s;
            c_s_col  <= enc_s_col_s;
        end else begin
            c_l_rall <= c_l_rall;
            c_l_row  <= c_l_row;
            c_l_col  <= c_l_col;
            c_m_rall <= c_m_rall;
            c_m_row  <= c_m_row;
            c_m_col  <= c_m_col;
            c_s_rall <= c_s_rall;
            c_s_row  <= c_s_row;
            c_s_col  <= c_s_col;
        end
    end

endmodule
